// File: rtl/ecpa_pkg.sv
// Shared constants and FSM state type for the modular inversion engine.
package ecpa_pkg;

    localparam int unsigned WIDTH  = 256;
    localparam int unsigned MAXCYC = 2 * WIDTH;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/mod_sub.sv
// Combinational (x - y) mod m for x, y in [0, m); the borrow selects the +m correction.
module mod_sub #(
    parameter int unsigned WIDTH = ecpa_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] diff
);

    logic [WIDTH:0] raw;

    // Low WIDTH bits of a borrowed difference equal x - y + 2^WIDTH, so adding m wraps to x - y + m.
    always_comb begin
        raw  = {1'b0, x} - {1'b0, y};
        diff = raw[WIDTH-1:0] + (raw[WIDTH] ? m : '0);
    end

endmodule

// File: rtl/modular_inversion.sv
// Modular inverse a^-1 mod m (m odd) by binary extended Euclid, one reduction step per RUN cycle.
module modular_inversion #(
    parameter int unsigned WIDTH = ecpa_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] inv,
    output logic             busy,
    output logic             ready,
    output logic             error
);
    import ecpa_pkg::*;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d, m_q, m_d;
    logic [WIDTH-1:0] inv_q, inv_d;
    logic             err_q, err_d;
    logic             legal, u_one, v_one, u_zero, v_zero;
    logic [WIDTH:0]   x1_sum, x2_sum;
    logic [WIDTH-1:0] x1_half, x2_half, x1_sub, x2_sub;

    assign legal  = (a != '0) && (a < m) && m[0] && (m != WIDTH'(1));
    assign u_one  = (u_q == WIDTH'(1));
    assign v_one  = (v_q == WIDTH'(1));
    assign u_zero = (u_q == '0);
    assign v_zero = (v_q == '0);

    // Odd x is made even by adding m at full width before halving, keeping x/2 mod m exact.
    assign x1_sum  = {1'b0, x1_q} + {1'b0, m_q};
    assign x2_sum  = {1'b0, x2_q} + {1'b0, m_q};
    assign x1_half = x1_q[0] ? WIDTH'(x1_sum >> 1) : (x1_q >> 1);
    assign x2_half = x2_q[0] ? WIDTH'(x2_sum >> 1) : (x2_q >> 1);

    mod_sub #(.WIDTH(WIDTH)) u_sub_x1 (.x(x1_q), .y(x2_q), .m(m_q), .diff(x1_sub));
    mod_sub #(.WIDTH(WIDTH)) u_sub_x2 (.x(x2_q), .y(x1_q), .m(m_q), .diff(x2_sub));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            inv_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            inv_q   <= inv_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        u_q  <= u_d;
        v_q  <= v_d;
        x1_q <= x1_d;
        x2_q <= x2_d;
        m_q  <= m_d;
    end

    // A new start wins in every state, including a RUN cycle that would otherwise terminate.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = legal ? StRun : StDone;
        end else begin
            unique case (state_q)
                StIdle:  state_d = StIdle;
                StRun:   if (u_one || v_one || u_zero || v_zero) state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        u_d   = u_q;
        v_d   = v_q;
        x1_d  = x1_q;
        x2_d  = x2_q;
        m_d   = m_q;
        inv_d = inv_q;
        err_d = err_q;
        if (start) begin
            u_d   = a;
            v_d   = m;
            x1_d  = WIDTH'(1);
            x2_d  = '0;
            m_d   = m;
            inv_d = '0;
            err_d = !legal;
        end else if (state_q == StRun) begin
            if (u_one || v_one) begin
                inv_d = u_one ? x1_q : x2_q;
            end else if (u_zero || v_zero) begin
                err_d = 1'b1;
            end else if (!u_q[0]) begin
                u_d  = u_q >> 1;
                x1_d = x1_half;
            end else if (!v_q[0]) begin
                v_d  = v_q >> 1;
                x2_d = x2_half;
            end else if (u_q >= v_q) begin
                u_d  = u_q - v_q;
                x1_d = x1_sub;
            end else begin
                v_d  = v_q - u_q;
                x2_d = x2_sub;
            end
        end
    end

    always_comb begin
        busy  = 1'b0;
        ready = 1'b0;
        unique case (state_q)
            StRun:   busy  = 1'b1;
            StDone:  ready = 1'b1;
            default: ;
        endcase
    end

    assign inv   = inv_q;
    assign error = err_q;

endmodule

// File: tb/tb_modular_inversion.sv
// Scoreboard bench for modular_inversion: directed cases, control scenarios, random operands.
module tb_modular_inversion;
    import ecpa_pkg::*;

    localparam int unsigned W = WIDTH;
    localparam logic [W-1:0] P256 =
        256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] m;
        logic [W-1:0] inv;
        logic         err;
        int           run;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] m = '0;
    logic [W-1:0] inv;
    logic         busy, ready, error;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   run_cnt = 0;
    int   since = 0;

    modular_inversion #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .m     (m),
        .inv   (inv),
        .busy  (busy),
        .ready (ready),
        .error (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Plain extended Euclid over signed integers; the inverse in [0, m) is unique.
    function automatic void ref_inv(input longint aa, input longint mm,
                                    output longint inv_o, output logic err_o);
        longint r0, r1, t0, t1, q, tmp;
        r0 = mm;
        r1 = aa;
        t0 = 0;
        t1 = 1;
        while (r1 != 0) begin
            q   = r0 / r1;
            tmp = r0 - q * r1;
            r0  = r1;
            r1  = tmp;
            tmp = t0 - q * t1;
            t0  = t1;
            t1  = tmp;
        end
        err_o = (r0 != 1);
        inv_o = err_o ? 0 : ((t0 < 0) ? t0 + mm : t0);
    endfunction

    task automatic check_ready();
        exp_t         e;
        logic [2*W-1:0] prod;
        chk("ready_expected", W'(sb.size() != 0), W'(1));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("inv", inv, e.inv);
            chk("error", W'(error), W'(e.err));
            chk("busy_at_ready", W'(busy), '0);
            chk("run_le_maxcyc", W'(run_cnt <= int'(MAXCYC)), W'(1));
            chk("latency", W'(since), W'(run_cnt + 1));
            if (e.run >= 0) chk("run_cycles", W'(run_cnt), W'(e.run));
            if (!e.err) begin
                prod = ({{W{1'b0}}, e.a} * {{W{1'b0}}, inv}) % {{W{1'b0}}, e.m};
                chk("a_times_inv", prod[W-1:0], W'(1));
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n || start) begin
                run_cnt = 0;
                since   = 0;
            end else begin
                since++;
                if (busy) run_cnt++;
                if (ready) check_ready();
            end
        end
    end

    task automatic expect_op(input logic [W-1:0] aa, input logic [W-1:0] mm,
                             input logic [W-1:0] ei, input logic ee, input int rr);
        exp_t e;
        e.a   = aa;
        e.m   = mm;
        e.inv = ei;
        e.err = ee;
        e.run = rr;
        sb.push_back(e);
    endtask

    // Operands are scrambled after the start cycle; the DUT must ignore them.
    task automatic issue(input logic [W-1:0] aa, input logic [W-1:0] mm);
        @(posedge clk);
        #1;
        a     = aa;
        m     = mm;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom());
        m     = W'($urandom());
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 4 * int'(MAXCYC)) begin
            @(posedge clk);
            n++;
        end
        chk("done_in_time", W'(sb.size()), '0);
        sb.delete();
    endtask

    task automatic do_op(input logic [W-1:0] aa, input logic [W-1:0] mm,
                         input logic [W-1:0] ei, input logic ee, input int rr);
        expect_op(aa, mm, ei, ee, rr);
        issue(aa, mm);
        wait_done();
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0]    half_p;
        int unsigned     bits;
        longint unsigned mm, aa;
        longint          ei;
        logic            ee;

        #2 rst_n = 1'b0;
        #10;
        chk("rst_inv", inv, '0);
        chk("rst_busy", W'(busy), '0);
        chk("rst_ready", W'(ready), '0);
        chk("rst_error", W'(error), '0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        do_op(W'(3), W'(7), W'(5), 1'b0, -1);
        repeat (3) @(posedge clk);
        #1 chk("inv_hold", inv, W'(5));
        do_op(W'(2), W'(13), W'(7), 1'b0, -1);
        do_op(W'(6), W'(15), '0, 1'b1, -1);
        do_op(W'(1), W'(7), W'(1), 1'b0, 1);
        do_op(W'(0), W'(7), '0, 1'b1, 0);
        do_op(W'(7), W'(7), '0, 1'b1, 0);
        do_op(W'(3), W'(10), '0, 1'b1, 0);
        do_op(W'(9), W'(7), '0, 1'b1, 0);

        half_p = (P256 + W'(1)) >> 1;
        do_op(W'(2), P256, half_p, 1'b0, -1);
        do_op(P256 - W'(1), P256, P256 - W'(1), 1'b0, -1);

        // Abort a long inversion mid-RUN; only the replacement may complete.
        do_op(W'(3), W'(7), W'(5), 1'b0, -1);
        issue(P256 - W'(1), P256);
        chk("inv_clear_on_start", inv, '0);
        repeat (3) @(posedge clk);
        #1 chk("busy_mid_run", W'(busy), W'(1));
        expect_op(W'(3), W'(11), W'(4), 1'b0, -1);
        issue(W'(3), W'(11));
        wait_done();

        // Restart in the very RUN cycle where a=1 would terminate.
        @(posedge clk);
        #1;
        a     = W'(1);
        m     = W'(7);
        start = 1'b1;
        @(posedge clk);
        #1;
        a = W'(3);
        m = W'(11);
        expect_op(W'(3), W'(11), W'(4), 1'b0, -1);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();

        // Reset clears held outputs at once, then again mid-RUN.
        do_op(W'(6), W'(15), '0, 1'b1, -1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("rst_idle_error", W'(error), '0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        issue(P256 - W'(1), P256);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_run_busy", W'(busy), '0);
        chk("rst_run_ready", W'(ready), '0);
        chk("rst_run_inv", inv, '0);
        chk("rst_run_error", W'(error), '0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        do_op(W'(3), W'(7), W'(5), 1'b0, -1);

        for (int i = 0; i < 1000; i++) begin
            bits = $urandom_range(20, 2);
            mm   = {32'd0, $urandom()} & ((64'd1 << bits) - 64'd1);
            mm   = mm | 64'd1;
            if (mm < 3) mm = 3;
            aa = {32'd0, $urandom_range(32'(mm - 1), 1)};
            ref_inv(longint'(aa), longint'(mm), ei, ee);
            do_op(W'(aa), W'(mm), W'(ei), ee, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/modular_inversion.md
MODULAR_INVERSION -- requirements
Module: modular_inversion

Interface
REQ-001 Parameter: WIDTH, default 256, operand/modulus bit width.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  single-cycle request; samples a and m.
REQ-005 a  input  WIDTH  value to invert; must satisfy 0 < a < m.
REQ-006 m  input  WIDTH  modulus; must be odd and > 1.
REQ-007 inv  output  WIDTH  result a^-1 mod m; valid from the ready pulse until the next start.
REQ-008 busy  output  1  high while an inversion is in progress.
REQ-009 ready  output  1  one-cycle completion pulse.
REQ-010 error  output  1  set with ready when no inverse exists or inputs are illegal; held until next start.

Function
REQ-011 Algorithm SHALL be binary extended Euclid: u=a, v=m, x1=1, x2=0; exactly one step per RUN cycle.
REQ-012 FSM states SHALL be IDLE, RUN, DONE.
REQ-013 IDLE->RUN on start when inputs are legal; IDLE->DONE with error=1 when a==0, a>=m, m even or m<=1.
REQ-014 RUN step priority, evaluated on the current registers:
  (1) u==1 or v==1 -> DONE, inv = (u==1 ? x1 : x2);
  (2) u==0 or v==0 -> DONE, error=1, inv=0;
  (3) u even -> u=u>>1, x1 = x1 even ? x1>>1 : (x1+m)>>1;
  (4) v even -> v=v>>1, x2 halved by the same rule;
  (5) u>=v -> u=u-v, x1=(x1-x2) mod m;
  (6) otherwise v=v-u, x2=(x2-x1) mod m.
REQ-015 (x1+m) SHALL be computed at WIDTH+1 bits before the shift; no truncation.
REQ-016 Modular subtraction SHALL compute at WIDTH+1 bits and add m when the borrow bit is set; the result lies in [0, m).
REQ-017 x1 and x2 SHALL remain in [0, m) at all times.
REQ-018 RUN SHALL take at most 2*WIDTH cycles; latency from start to ready is 1 + RUN cycles + 1.
REQ-019 DONE SHALL last one cycle: ready=1, busy=0; it then returns to IDLE.
REQ-020 busy SHALL be 1 in RUN only.
REQ-021 start asserted in RUN or DONE SHALL abort the current operation and restart with the new operands; no ready pulse is issued for the aborted operation.
REQ-022 start asserted in the same cycle as a RUN termination condition SHALL take priority; no ready pulse is issued.
REQ-023 a and m SHALL be sampled only on start; input changes during RUN have no effect.
REQ-024 inv and error SHALL clear to 0 on start and update only on entry to DONE.

Reset
REQ-025 rst_n low SHALL force state IDLE and set inv=0, busy=0, ready=0, error=0 immediately, including mid-operation.
REQ-026 Internal u, v, x1 and x2 need no reset value.
REQ-027 The first start after reset release SHALL behave as from IDLE.

Structure
REQ-028 Shared package ecpa_pkg SHALL hold WIDTH default 256, the FSM state enum, and constant MAXCYC = 2*WIDTH.
REQ-029 One combinational sub-module, mod_sub, SHALL compute (x - y) mod m at WIDTH+1 bits; it is instantiated twice (x1-x2 and x2-x1) or once with muxed operands.
REQ-030 Halving logic and comparators SHALL stay inline; no multiplier is used.

Verification
REQ-031 m=7, a=3, start -> ready pulse, inv=5, error=0, busy low after ready.
REQ-032 m=13, a=2 -> inv=7; m=15, a=6 (gcd 3) -> ready with error=1, inv=0.
REQ-033 a=1 -> inv=1 after exactly 1 RUN cycle; a=0, a=m, or m=10 -> ready on the 2nd cycle after start with error=1 and busy never high.
REQ-034 m = P-256 prime, a=2 -> inv=(m+1)/2; a=m-1 -> inv=m-1; each completes within 512 RUN cycles.
REQ-035 Random-stimulus check: 1000 random odd m with a<m -> (a*inv) mod m == 1 whenever gcd=1, otherwise error=1; RUN count never exceeds MAXCYC.
REQ-036 Control scenarios: start re-asserted mid-RUN with m=11, a=3 -> single ready, inv=4; rst_n pulsed mid-RUN -> outputs zero immediately, no ready pulse.
